// File: rtl/ttt_pkg.sv
// Shared board definitions for the 3x3 tic-tac-toe datapath: cell count,
// cell-index width and cursor wrap helpers used by the input stage,
// the cell decoder and the board-state logic.
package ttt_pkg;

    localparam int N_CELLS = 9;
    localparam int CELL_W  = 4;

    typedef logic [CELL_W-1:0] pos_t;

    // Step forward with wrap by comparison; indices above last are never produced.
    function automatic pos_t pos_inc(input pos_t p, input int n_cells);
        return (p == pos_t'(n_cells - 1)) ? pos_t'(0) : p + pos_t'(1);
    endfunction

    // Step backward with wrap by comparison.
    function automatic pos_t pos_dec(input pos_t p, input int n_cells);
        return (p == pos_t'(0)) ? pos_t'(n_cells - 1) : p - pos_t'(1);
    endfunction

endpackage

// File: rtl/selector_posicion_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, counter debouncer and a
// registered rising-edge detector that yields a one-cycle press pulse.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: any return to the accepted level restarts the stability count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_d = level_q & ~level_dly_q;
    end

    // State registers; reset discards any partially debounced press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/selector_posicion.sv
// Board cursor: conditions next/prev/select buttons, moves a cursor over
// the cells with wrap, and strobes the chosen cell or flags a select on
// an occupied cell.
module selector_posicion
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int N_CELLS         = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_sel,
    input  logic [N_CELLS-1:0] occupied,
    output logic [CELL_W-1:0] posicion_output,
    output logic              sel_valid,
    output logic              sel_rejected
);

    localparam int BTN_NEXT = 0;
    localparam int BTN_PREV = 1;
    localparam int BTN_SEL  = 2;

    logic [2:0] raw_btn;
    logic [2:0] press;

    pos_t cursor_q, cursor_d;
    logic valid_q, valid_d;
    logic rej_q, rej_d;

    assign raw_btn = {btn_sel, btn_prev, btn_next};

    // One identical conditioner per button.
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_btn[gi]),
            .press(press[gi])
        );
    end

    // Select wins over moves; opposing moves in the same cycle cancel.
    always_comb begin
        cursor_d = cursor_q;
        valid_d  = 1'b0;
        rej_d    = 1'b0;
        if (press[BTN_SEL]) begin
            valid_d = ~occupied[cursor_q];
            rej_d   = occupied[cursor_q];
        end else if (press[BTN_NEXT] && !press[BTN_PREV]) begin
            cursor_d = pos_inc(cursor_q, N_CELLS);
        end else if (press[BTN_PREV] && !press[BTN_NEXT]) begin
            cursor_d = pos_dec(cursor_q, N_CELLS);
        end
    end

    // Cursor and strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor_q <= '0;
            valid_q  <= 1'b0;
            rej_q    <= 1'b0;
        end else begin
            cursor_q <= cursor_d;
            valid_q  <= valid_d;
            rej_q    <= rej_d;
        end
    end

    assign posicion_output = cursor_q;
    assign sel_valid       = valid_q;
    assign sel_rejected    = rej_q;

endmodule

// File: tb/tb_selector_posicion.sv
// Directed bench for selector_posicion with a short debounce window.
module tb_selector_posicion;

    localparam int DEB     = 4;
    localparam int LAT     = DEB + 4;
    localparam int HOLD    = 10;
    localparam int GAP     = 10;

    logic       clk;
    logic       rst;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_sel;
    logic [8:0] occupied;
    logic [3:0] posicion_output;
    logic       sel_valid;
    logic       sel_rejected;

    int checks;
    int failures;

    selector_posicion #(
        .DEBOUNCE_CYCLES(DEB),
        .N_CELLS        (9)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_next       (btn_next),
        .btn_prev       (btn_prev),
        .btn_sel        (btn_sel),
        .occupied       (occupied),
        .posicion_output(posicion_output),
        .sel_valid      (sel_valid),
        .sel_rejected   (sel_rejected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       nxt;
        logic       prv;
        logic       sel;
        logic [8:0] occ;
        logic [3:0] exp_pos;
        logic       exp_valid;
        logic       exp_rej;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic chk_outputs(input string name, input int cyc, input int pos,
                               input int v, input int r);
        chk({name, ".pos"},   cyc, int'(posicion_output), pos);
        chk({name, ".valid"}, cyc, int'(sel_valid), v);
        chk({name, ".rej"},   cyc, int'(sel_rejected), r);
    endtask

    // Raise the buttons of one vector, hold, release, and watch every cycle.
    task automatic apply_vec(input vec_t v, input logic [3:0] prev_pos);
        int ev;
        int er;
        int ep;
        @(posedge clk); #1;
        btn_next = v.nxt;
        btn_prev = v.prv;
        btn_sel  = v.sel;
        occupied = v.occ;
        for (int n = 1; n <= HOLD + GAP; n++) begin
            @(posedge clk); #1;
            ep = (n < LAT) ? int'(prev_pos) : int'(v.exp_pos);
            ev = (n == LAT) ? int'(v.exp_valid) : 0;
            er = (n == LAT) ? int'(v.exp_rej) : 0;
            chk_outputs(v.name, n, ep, ev, er);
            if (n == HOLD) begin
                btn_next = 1'b0;
                btn_prev = 1'b0;
                btn_sel  = 1'b0;
            end
        end
        $display("vec %-10s nxt=%b prv=%b sel=%b occ=%b pos=%0d valid_exp=%b rej_exp=%b",
                 v.name, v.nxt, v.prv, v.sel, v.occ, posicion_output, v.exp_valid, v.exp_rej);
    endtask

    function automatic vec_t mk(input string name, input logic nxt, input logic prv,
                                input logic sel, input logic [8:0] occ, input logic [3:0] pos,
                                input logic vv, input logic rr);
        vec_t v;
        v.name = name; v.nxt = nxt; v.prv = prv; v.sel = sel; v.occ = occ;
        v.exp_pos = pos; v.exp_valid = vv; v.exp_rej = rr;
        return v;
    endfunction

    initial begin
        logic [3:0] cur;
        checks   = 0;
        failures = 0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        btn_sel  = 1'b0;
        occupied = 9'b0;
        rst      = 1'b1;

        // Next wrap 1..8,0
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk($sformatf("next%0d", i), 1'b1, 1'b0, 1'b0, 9'b0, 4'(i % 9), 1'b0, 1'b0));
        // Prev wrap 0 -> 8 -> 7, then down to 3
        vecs.push_back(mk("prev8", 1'b0, 1'b1, 1'b0, 9'b0, 4'd8, 1'b0, 1'b0));
        vecs.push_back(mk("prev7", 1'b0, 1'b1, 1'b0, 9'b0, 4'd7, 1'b0, 1'b0));
        vecs.push_back(mk("prev6", 1'b0, 1'b1, 1'b0, 9'b0, 4'd6, 1'b0, 1'b0));
        vecs.push_back(mk("prev5", 1'b0, 1'b1, 1'b0, 9'b0, 4'd5, 1'b0, 1'b0));
        vecs.push_back(mk("prev4", 1'b0, 1'b1, 1'b0, 9'b0, 4'd4, 1'b0, 1'b0));
        vecs.push_back(mk("prev3", 1'b0, 1'b1, 1'b0, 9'b0, 4'd3, 1'b0, 1'b0));
        // Select free / occupied / other cells occupied
        vecs.push_back(mk("sel_free", 1'b0, 1'b0, 1'b1, 9'b000000000, 4'd3, 1'b1, 1'b0));
        vecs.push_back(mk("sel_occ",  1'b0, 1'b0, 1'b1, 9'b000001000, 4'd3, 1'b0, 1'b1));
        vecs.push_back(mk("sel_other",1'b0, 1'b0, 1'b1, 9'b111110111, 4'd3, 1'b1, 1'b0));
        // Simultaneous presses
        vecs.push_back(mk("next_prev",1'b1, 1'b1, 1'b0, 9'b0, 4'd3, 1'b0, 1'b0));
        vecs.push_back(mk("sel_next", 1'b1, 1'b0, 1'b1, 9'b0, 4'd3, 1'b1, 1'b0));
        vecs.push_back(mk("sel_nxtocc",1'b1, 1'b0, 1'b1, 9'b000001000, 4'd3, 1'b0, 1'b1));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("reset", 0, 0, 0, 0);
        $display("reset pos=%0d valid=%b rej=%b", posicion_output, sel_valid, sel_rejected);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        cur = 4'd0;
        foreach (vecs[i]) begin
            apply_vec(vecs[i], cur);
            cur = vecs[i].exp_pos;
        end

        // Bounce: five 3-cycle highs separated by 1-cycle lows never qualify
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            btn_next = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                chk_outputs("bounce", k * 4 + c, int'(cur), 0, 0);
            end
            btn_next = 1'b0;
            @(posedge clk); #1;
            chk_outputs("bounce", k * 4 + 3, int'(cur), 0, 0);
        end
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            chk_outputs("bounce_tail", c, int'(cur), 0, 0);
        end
        $display("bounce pos=%0d expected=%0d", posicion_output, cur);

        // Reset mid-press: outputs clear at once, held button re-debounces once
        btn_next = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_outputs("rst_async", 0, 0, 0, 0);
        $display("rst_async pos=%0d valid=%b rej=%b", posicion_output, sel_valid, sel_rejected);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            @(posedge clk); #1;
            chk_outputs("rst_hold", n, (n < LAT) ? 0 : 1, 0, 0);
        end
        btn_next = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            chk_outputs("rst_release", n, 1, 0, 0);
        end
        $display("rst_hold pos=%0d expected=1", posicion_output);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/selector_posicion.md
# selector_posicion

Upstream input stage for the 3×3 board logic. Conditions three raw push-buttons (next, previous, select) with synchronization, debounce and rising-edge detection. Maintains a cursor over cells 0..8 and emits the chosen cell index with a one-cycle strobe. That index and strobe drive the 4-bit cell decoder directly. Selections of cells already marked occupied are refused and flagged instead of forwarded.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz).
- `N_CELLS`, default 9: number of board cells; the cursor range is 0..N_CELLS-1.
- `clk`  in  1  single system clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_next`  in  1  raw asynchronous button, active-high; advances the cursor.
- `btn_prev`  in  1  raw asynchronous button, active-high; moves the cursor back.
- `btn_sel`  in  1  raw asynchronous button, active-high; selects the cell under the cursor.
- `occupied`  in  9  bit i = 1 means cell i is already taken; sampled synchronously.
- `posicion_output`  out  4  registered cursor value, always 0..8.
- `sel_valid`  out  1  one-cycle strobe: `posicion_output` is a newly selected free cell.
- `sel_rejected`  out  1  one-cycle strobe: a select was attempted on an occupied cell.

## Operation
- **Per-button conditioning:**
  - 2-FF synchronizer, then debouncer, then rising-edge detector, giving a one-cycle `press_*` pulse.
  - Debouncer: the counter clears whenever the synchronized level equals the debounced level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the debounced level.
- **Holding a button** produces exactly one press; there is no auto-repeat. Release produces no pulse.
- **Cursor update** per cycle, in priority order:
  - `press_sel`: cursor unchanged. If `occupied[cursor]` == 0, pulse `sel_valid`; else pulse `sel_rejected`.
  - `press_next` and `press_prev` in the same cycle: no move.
  - `press_next` alone: cursor = (cursor == 8) ? 0 : cursor + 1.
  - `press_prev` alone: cursor = (cursor == 0) ? 8 : cursor - 1.
- **Next/prev in the same cycle as sel** are dropped.
- **Arithmetic:** cursor is 4 bits wide. Wrap is by compare, never modulo-16, so values 9..15 are unreachable.
- **Reset values** (all asynchronous on `rst`):
  - cursor and `posicion_output` = 0.
  - `sel_valid` and `sel_rejected` = 0.
  - Synchronizers, debounced levels, edge registers and counters = 0.
  - A press in progress when reset asserts is discarded.
- **After reset release:** a button already held high must still complete a full debounce before it yields one press.

## Timing
- Raw input goes high and stays high at cycle 0.
- Synchronized level is valid at cycle 2.
- Debounced level rises at cycle 2 + DEBOUNCE_CYCLES.
- `press_*` is high for the following cycle.
- Cursor, `posicion_output`, `sel_valid` and `sel_rejected` update at the next edge: 1 cycle after `press_*`.
- Total latency from a clean edge to output: DEBOUNCE_CYCLES + 4 cycles.
- `sel_valid` and `sel_rejected` are each high for exactly 1 cycle and are mutually exclusive.
- `posicion_output` is stable during the strobe and holds until the next move.
- `occupied` is sampled in the same cycle as `press_sel`.

## Structure
- **Shared package `ttt_pkg`:**
  - `N_CELLS = 9`
  - `CELL_W = 4`
  - `typedef logic [CELL_W-1:0] pos_t`
  - Reused by the decoder and the board-state logic.
- **Sub-module `debouncer`:** parameter DEBOUNCE_CYCLES; ports `clk`, `rst`, `raw`, `press`. Contains the synchronizer, counter and edge detector. Instantiated three times.
- **Top:** cursor register and the select/reject logic only.

## Test plan
All tests run with DEBOUNCE_CYCLES = 4.
- **Reset:** assert `rst` mid-run with `btn_next` held. Expect `posicion_output` = 0 and both strobes 0 immediately. After release, exactly one press is seen, and the cursor reaches 1 eight cycles later.
- **Next wrap:** 9 clean `btn_next` presses, each held 10 cycles with 10-cycle gaps. `posicion_output` steps 1,2,…,8,0, each update 8 cycles after the raw edge.
- **Prev wrap:** from 0, one `btn_prev` press gives 8; a second gives 7.
- **Bounce rejection:** `btn_next` pulses high for 3 cycles, five times, separated by 1-cycle lows. Cursor is unchanged and no strobe occurs.
- **Select:**
  - Cursor at 3 with `occupied` = 9'b0: press `btn_sel`. `sel_valid` is high for 1 cycle with `posicion_output` = 3.
  - Set `occupied[3]` = 1 and press again: `sel_rejected` is high for 1 cycle and `sel_valid` stays 0.
- **Simultaneous presses:**
  - `btn_next` and `btn_prev` with identical edges: no cursor change.
  - `btn_sel` and `btn_next` with identical edges: the select strobe fires and the cursor is unchanged.
